// File: rtl/icb_word_copier_pkg.sv
// Shared definitions for the ICB word copier: FSM encoding, error codes,
// write-mask constants and address alignment.
package icb_word_copier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_RSP,
        ST_WR_CMD,
        ST_WR_RSP,
        ST_FIN
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_RD   = 2'd1;
    localparam logic [1:0] ERR_WR   = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [3:0] WMASK_FULL = 4'b1111;
    localparam logic [3:0] WMASK_NONE = 4'b0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icb_word_copier_if.sv
// ICB command/response channel bundle with initiator (master) and
// responder (slave) views.
interface icb_word_copier_if;

    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_valid;
    logic        rsp_ready;

    modport master (
        output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
        input  cmd_ready, rsp_rdata, rsp_err, rsp_valid
    );

    modport slave (
        input  cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
        output cmd_ready, rsp_rdata, rsp_err, rsp_valid
    );

endinterface

// File: rtl/icb_word_copier_handshake_timeout.sv
// Wait-cycle counter for an ICB handshake: clr restarts it, en counts a cycle
// without the awaited handshake, expired flags the TIMEOUT_TH-th such cycle.
module icb_handshake_timeout #(
    parameter int TIMEOUT_TH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_TH > 1) ? $clog2(TIMEOUT_TH) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // TIMEOUT_TH == 0 turns the watchdog off entirely.
    generate
        if (TIMEOUT_TH == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = en && (cnt == CNT_W'(TIMEOUT_TH - 1));
        end
    endgenerate

endmodule

// File: rtl/icb_word_copier.sv
// ICB initiator that copies len 32-bit words from src_addr to dst_addr,
// one outstanding transaction at a time (read word, write word, repeat).
module icb_word_copier #(
    parameter int  LEN_W            = 16,
    parameter int  TIMEOUT_TH       = 16,
    parameter real simulation_delay = 1.0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [LEN_W-1:0]   words_done,
    icb_word_copier_if.master  m_icb
);

    import icb_word_copier_pkg::*;

    // Outputs come straight from flops; simulation_delay is only meaningful to
    // behavioural models that share this parameter list.
    generate
        if (simulation_delay < 0.0) begin : g_neg_delay
        end
    endgenerate

    state_t state, state_nxt;

    logic [31:0]      src_cur, src_nxt;
    logic [31:0]      dst_cur, dst_nxt;
    logic [LEN_W-1:0] len_lat, len_nxt;

    logic             busy_nxt, done_nxt, err_nxt;
    logic [1:0]       err_code_nxt;
    logic [LEN_W-1:0] words_done_nxt, words_inc;
    logic [31:0]      addr_nxt, wdata_nxt;
    logic [3:0]       wmask_nxt;
    logic             read_nxt, valid_nxt, rsp_ready_nxt;

    logic tmo_clr, tmo_en, tmo_expired;

    assign words_inc = words_done + LEN_W'(1);
    assign tmo_clr   = (state_nxt != state);
    assign tmo_en    = (state == ST_RD_CMD) || (state == ST_RD_RSP) ||
                       (state == ST_WR_CMD) || (state == ST_WR_RSP);

    icb_handshake_timeout #(
        .TIMEOUT_TH (TIMEOUT_TH)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        src_nxt        = src_cur;
        dst_nxt        = dst_cur;
        len_nxt        = len_lat;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        err_nxt        = err;
        err_code_nxt   = err_code;
        words_done_nxt = words_done;
        addr_nxt       = m_icb.cmd_addr;
        read_nxt       = m_icb.cmd_read;
        wdata_nxt      = m_icb.cmd_wdata;
        wmask_nxt      = m_icb.cmd_wmask;
        valid_nxt      = m_icb.cmd_valid;
        rsp_ready_nxt  = m_icb.rsp_ready;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    err_nxt        = 1'b0;
                    err_code_nxt   = ERR_NONE;
                    words_done_nxt = '0;
                    if (len != '0) begin
                        src_nxt   = word_align(src_addr);
                        dst_nxt   = word_align(dst_addr);
                        len_nxt   = len;
                        busy_nxt  = 1'b1;
                        valid_nxt = 1'b1;
                        read_nxt  = 1'b1;
                        wmask_nxt = WMASK_NONE;
                        addr_nxt  = word_align(src_addr);
                        state_nxt = ST_RD_CMD;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_RD_CMD: begin
                if (m_icb.cmd_ready) begin
                    valid_nxt     = 1'b0;
                    rsp_ready_nxt = 1'b1;
                    state_nxt     = ST_RD_RSP;
                end else if (tmo_expired) begin
                    valid_nxt    = 1'b0;
                    err_code_nxt = ERR_TMO;
                    state_nxt    = ST_FIN;
                end
            end
            ST_RD_RSP: begin
                if (m_icb.rsp_valid) begin
                    rsp_ready_nxt = 1'b0;
                    if (m_icb.rsp_err) begin
                        err_code_nxt = ERR_RD;
                        state_nxt    = ST_FIN;
                    end else begin
                        wdata_nxt = m_icb.rsp_rdata;
                        valid_nxt = 1'b1;
                        read_nxt  = 1'b0;
                        wmask_nxt = WMASK_FULL;
                        addr_nxt  = dst_cur;
                        state_nxt = ST_WR_CMD;
                    end
                end else if (tmo_expired) begin
                    rsp_ready_nxt = 1'b0;
                    err_code_nxt  = ERR_TMO;
                    state_nxt     = ST_FIN;
                end
            end
            ST_WR_CMD: begin
                if (m_icb.cmd_ready) begin
                    valid_nxt     = 1'b0;
                    rsp_ready_nxt = 1'b1;
                    state_nxt     = ST_WR_RSP;
                end else if (tmo_expired) begin
                    valid_nxt    = 1'b0;
                    err_code_nxt = ERR_TMO;
                    state_nxt    = ST_FIN;
                end
            end
            ST_WR_RSP: begin
                if (m_icb.rsp_valid) begin
                    rsp_ready_nxt = 1'b0;
                    if (m_icb.rsp_err) begin
                        err_code_nxt = ERR_WR;
                        state_nxt    = ST_FIN;
                    end else begin
                        words_done_nxt = words_inc;
                        src_nxt        = src_cur + 32'd4;
                        dst_nxt        = dst_cur + 32'd4;
                        if (words_inc == len_lat) begin
                            state_nxt = ST_FIN;
                        end else begin
                            valid_nxt = 1'b1;
                            read_nxt  = 1'b1;
                            wmask_nxt = WMASK_NONE;
                            addr_nxt  = src_cur + 32'd4;
                            state_nxt = ST_RD_CMD;
                        end
                    end
                end else if (tmo_expired) begin
                    rsp_ready_nxt = 1'b0;
                    err_code_nxt  = ERR_TMO;
                    state_nxt     = ST_FIN;
                end
            end
            ST_FIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                err_nxt   = (err_code != ERR_NONE);
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            err_code        <= ERR_NONE;
            words_done      <= '0;
            m_icb.cmd_addr  <= '0;
            m_icb.cmd_read  <= 1'b1;
            m_icb.cmd_wdata <= '0;
            m_icb.cmd_wmask <= WMASK_NONE;
            m_icb.cmd_valid <= 1'b0;
            m_icb.rsp_ready <= 1'b0;
        end else begin
            busy            <= busy_nxt;
            done            <= done_nxt;
            err             <= err_nxt;
            err_code        <= err_code_nxt;
            words_done      <= words_done_nxt;
            m_icb.cmd_addr  <= addr_nxt;
            m_icb.cmd_read  <= read_nxt;
            m_icb.cmd_wdata <= wdata_nxt;
            m_icb.cmd_wmask <= wmask_nxt;
            m_icb.cmd_valid <= valid_nxt;
            m_icb.rsp_ready <= rsp_ready_nxt;
        end
    end

    // Copy cursors are pure datapath and are always loaded before use.
    always_ff @(posedge clk) begin
        src_cur <= src_nxt;
        dst_cur <= dst_nxt;
        len_lat <= len_nxt;
    end

endmodule
